rom_sweep_checker: RTL and testbench

- Hardware reader for the ROM interface: sweeps every address once, captures read data from two ROM instances (golden model and post-route netlist) after a fixed read latency, and compares them word by word.
- Accumulates a mismatch count, the first failing address, and an additive checksum of the golden data.
- Sits beside the ROM under test as on-chip self-check logic, giving the same pass/fail verdict the simulation bench gives, but in synthesizable form.

---
 rtl/rom_sweep_checker.sv | 116 +++++++++++
 tb/tb_rom_sweep_checker.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_sweep_checker.sv
// Sweeps the whole ROM address space once per start and compares golden against
// netlist read data. Tracks the mismatch count, the first failing address and a checksum.
module rom_sweep_checker #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_gold,
    input  logic [DATA_W-1:0] data_dut,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       mismatch_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [15:0]       checksum
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                           r_state;
    logic [ADDR_W-1:0]                r_address;
    logic                             r_busy;
    logic                             r_done;
    logic [15:0]                      r_mismatch_cnt;
    logic [ADDR_W-1:0]                r_first_err_addr;
    logic [15:0]                      r_checksum;
    logic [READ_LAT-1:0]              r_pipe_vld;
    logic [READ_LAT-1:0][ADDR_W-1:0]  r_pipe_tag;

    logic                             w_push;
    logic [READ_LAT:0]                w_vld_next;
    logic [READ_LAT:0][ADDR_W-1:0]    w_tag_next;
    logic                             w_cap_vld;
    logic [ADDR_W-1:0]                w_cap_tag;
    logic                             w_cap_err;

    // Element 0 of each next-vector is the newly issued read; the top element falls off.
    assign w_push     = (r_state == ISSUE);
    assign w_vld_next = {r_pipe_vld, w_push};
    assign w_tag_next = {r_pipe_tag, r_address};
    assign w_cap_vld  = r_pipe_vld[READ_LAT-1];
    assign w_cap_tag  = r_pipe_tag[READ_LAT-1];
    assign w_cap_err  = w_cap_vld && (data_gold != data_dut);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_address        <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_mismatch_cnt   <= '0;
            r_first_err_addr <= '0;
            r_checksum       <= '0;
            r_pipe_vld       <= '0;
            r_pipe_tag       <= '0;
        end else begin
            r_pipe_vld <= w_vld_next[READ_LAT-1:0];
            r_pipe_tag <= w_tag_next[READ_LAT-1:0];

            if (w_cap_vld) begin
                r_checksum <= r_checksum + 16'(data_gold);
                if (w_cap_err) begin
                    if (r_mismatch_cnt != '1) begin
                        r_mismatch_cnt <= r_mismatch_cnt + 16'd1;
                    end
                    if (r_mismatch_cnt == '0) begin
                        r_first_err_addr <= w_cap_tag;
                    end
                end
            end

            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_mismatch_cnt   <= '0;
                        r_first_err_addr <= '0;
                        r_checksum       <= '0;
                        r_done           <= 1'b0;
                        r_address        <= '0;
                        r_busy           <= 1'b1;
                        r_state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (r_address == '1) begin
                        r_state <= DRAIN;
                    end else begin
                        r_address <= r_address + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (r_pipe_vld == '0) begin
                        r_state   <= DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_address <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign address        = r_address;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_done && (r_mismatch_cnt == '0);
    assign mismatch_cnt   = r_mismatch_cnt;
    assign first_err_addr = r_first_err_addr;
    assign checksum       = r_checksum;

endmodule

// File: tb/tb_rom_sweep_checker.sv
// Scoreboard bench for rom_sweep_checker: one instance with READ_LAT=1 and one with
// READ_LAT=3, each fed by a registered ROM model and run through the same scenarios.
module tb_rom_sweep_checker;

    typedef struct {
        int     cnt;
        int     first;
        int     cs;
        longint t0;
    } exp_t;

    logic        clk = 1'b0;
    int unsigned total = 0;
    int unsigned bad = 0;
    bit          fin [2];

    always #5 clk = ~clk;

    function automatic void chk(input int d, input string nm,
                                input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL dut%0d %s: got=%0h expected=%0h", d, nm, act, exp);
        end
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;

        logic        rst_n = 1'b0;
        logic        start = 1'b0;
        logic [7:0]  address;
        logic [7:0]  data_gold;
        logic [7:0]  data_dut;
        logic        busy;
        logic        done;
        logic        pass;
        logic [15:0] mismatch_cnt;
        logic [7:0]  first_err_addr;
        logic [15:0] checksum;

        logic [7:0]  gmem  [256];
        logic [7:0]  dmem  [256];
        logic [7:0]  gpipe [LAT];
        logic [7:0]  dpipe [LAT];
        exp_t        q [$];

        rom_sweep_checker #(
            .ADDR_W  (8),
            .DATA_W  (8),
            .READ_LAT(LAT)
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .start         (start),
            .address       (address),
            .data_gold     (data_gold),
            .data_dut      (data_dut),
            .busy          (busy),
            .done          (done),
            .pass          (pass),
            .mismatch_cnt  (mismatch_cnt),
            .first_err_addr(first_err_addr),
            .checksum      (checksum)
        );

        // Registered ROM pair with LAT output stages.
        always @(posedge clk) begin
            gpipe[0] <= gmem[address];
            dpipe[0] <= dmem[address];
            for (int i = 1; i < LAT; i++) begin
                gpipe[i] <= gpipe[i-1];
                dpipe[i] <= dpipe[i-1];
            end
        end
        assign data_gold = gpipe[LAT-1];
        assign data_dut  = dpipe[LAT-1];

        initial begin : mon
            logic prev;
            exp_t e;
            prev = 1'b0;
            forever begin
                @(posedge clk);
                #1;
                if (done && !prev) begin
                    chk(g, "sb_has_entry", q.size() != 0, 1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        chk(g, "latency", ($time - 1 - e.t0) / 10, 256 + LAT + 1);
                        chk(g, "mismatch_cnt", mismatch_cnt, e.cnt);
                        chk(g, "checksum", checksum, e.cs);
                        chk(g, "pass", pass, e.cnt == 0);
                        chk(g, "busy_at_done", busy, 0);
                        chk(g, "addr_at_done", address, 0);
                        if (e.cnt != 0) chk(g, "first_err_addr", first_err_addr, e.first);
                    end
                end
                prev = done;
            end
        end

        task automatic fill_identity();
            for (int i = 0; i < 256; i++) begin
                gmem[i] = 8'(i);
                dmem[i] = 8'(i);
            end
        endtask

        task automatic chk_reset(input string nm);
            chk(g, {nm, "_address"}, address, 0);
            chk(g, {nm, "_busy"}, busy, 0);
            chk(g, {nm, "_done"}, done, 0);
            chk(g, {nm, "_pass"}, pass, 0);
            chk(g, {nm, "_cnt"}, mismatch_cnt, 0);
            chk(g, {nm, "_first"}, first_err_addr, 0);
            chk(g, {nm, "_checksum"}, checksum, 0);
        endtask

        // Reference results come straight from the two memory images.
        task automatic do_start();
            exp_t e;
            e.cnt = 0;
            e.first = 0;
            e.cs = 0;
            for (int i = 0; i < 256; i++) begin
                e.cs += int'(gmem[i]);
                if (gmem[i] !== dmem[i]) begin
                    if (e.cnt == 0) e.first = i;
                    e.cnt++;
                end
            end
            e.cs = e.cs % 65536;
            start = 1'b1;
            @(posedge clk);
            e.t0 = $time;
            q.push_back(e);
            #1;
            start = 1'b0;
            chk(g, "busy_after_start", busy, 1);
            chk(g, "done_after_start", done, 0);
            chk(g, "addr_after_start", address, 0);
        endtask

        task automatic wait_done();
            int n = 0;
            while (!done && n < 400) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk(g, "done_within_bound", done, 1);
            repeat (2) @(posedge clk);
            #1;
        endtask

        initial begin : seq
            int unsigned k;
            fill_identity();
            repeat (3) @(posedge clk);
            #1;
            chk_reset("por");
            rst_n = 1'b1;

            do_start();
            wait_done();

            dmem[8'h5A] ^= 8'h08;
            do_start();
            wait_done();

            for (int i = 0; i < 256; i++) dmem[i] = ~gmem[i];
            do_start();
            wait_done();

            fill_identity();
            dmem[8'hFF] ^= 8'h01;
            do_start();
            wait_done();

            fill_identity();
            do_start();
            repeat (99) @(posedge clk);
            #1;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            chk(g, "busy_after_ignored_start", busy, 1);
            wait_done();

            do_start();
            repeat (49) @(posedge clk);
            #1;
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            q.delete();
            chk_reset("mid_reset");
            start = 1'b1;
            @(posedge clk);
            #1;
            chk(g, "reset_beats_start_busy", busy, 0);
            chk(g, "reset_beats_start_addr", address, 0);
            start = 1'b0;
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            do_start();
            wait_done();

            repeat (3) begin
                for (int i = 0; i < 256; i++) begin
                    gmem[i] = 8'($urandom_range(255));
                    dmem[i] = gmem[i];
                end
                k = $urandom_range(5);
                for (int unsigned j = 0; j < k; j++) begin
                    dmem[$urandom_range(255)] ^= 8'($urandom_range(255, 1));
                end
                do_start();
                wait_done();
            end
            fin[g] = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 20000 && !(fin[0] && fin[1]); i++) @(posedge clk);
        chk(0, "sequence_finished", fin[0], 1);
        chk(1, "sequence_finished", fin[1], 1);
        chk(0, "sb_drained", g_dut[0].q.size(), 0);
        chk(1, "sb_drained", g_dut[1].q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
